// File: rtl/ir_nec_rcv.sv
// NEC IR remote decoder: 1 us tick timing, frame/repeat decode, release timeout.
// Define IR_ADDR_CHECK_EN to also require addr ^ naddr == 8'hFF (strict NEC).
module ir_nec_rcv #(
  parameter int unsigned PRESCALE  = 27,
  parameter int unsigned REL_TO_US = 130000,
  parameter int unsigned TSCALE    = 1
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        ir_rx,
  output logic [15:0] ir_code,
  output logic [7:0]  ir_code_cnt,
  output logic        ir_valid
);
  localparam int unsigned PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned RLW      = $clog2(REL_TO_US + 1);
  // TSCALE divides every width window; it is 1 for real timing
  localparam int unsigned LM_LO    = 8000 / TSCALE;
  localparam int unsigned LM_HI    = 10000 / TSCALE;
  localparam int unsigned LS_LO    = 4000 / TSCALE;
  localparam int unsigned LS_HI    = 5000 / TSCALE;
  localparam int unsigned RS_LO    = 2000 / TSCALE;
  localparam int unsigned RS_HI    = 2500 / TSCALE;
  localparam int unsigned MK_LO    = 400 / TSCALE;
  localparam int unsigned MK_HI    = 700 / TSCALE;
  localparam int unsigned S1_LO    = 1400 / TSCALE;
  localparam int unsigned S1_HI    = 1900 / TSCALE;
  localparam int unsigned ABORT_TO = 12000 / TSCALE;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_REP_MARK
  } state_t;

  state_t          state_q, state_d;
  logic            rx_s1_q, rx_s2_q, rx_d1_q;
  logic            rise_pend_q, rise_pend_d, fall_pend_q, fall_pend_d;
  logic [PSW-1:0]  presc_q, presc_d;
  logic [15:0]     pw_q, pw_d;
  logic [4:0]      bit_idx_q, bit_idx_d;
  logic [31:0]     sr_q, sr_d;
  logic [RLW-1:0]  rel_q, rel_d;
  logic [15:0]     code_q, code_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;

  function automatic logic in_win(input logic [15:0] w, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic tick_c, rise_now_c, fall_now_c, abort_c, ev_c;
  logic mark_ok_c, zero_c, one_c, lead_ok_c, lsp_ok_c, rsp_ok_c;
  logic frame_start_c, bit_c, stop_ok_c, rep_ok_c, frame_ok_c, rep_acc_c, accept_c;
  logic addr_ok_c;

  assign tick_c     = (presc_q == PSW'(PRESCALE - 1));
  assign rise_now_c = rise_pend_q | (rx_s2_q & ~rx_d1_q);
  assign fall_now_c = fall_pend_q | (~rx_s2_q & rx_d1_q);
  assign abort_c    = tick_c && (state_q != S_IDLE) && (pw_q > 16'(ABORT_TO));
  assign ev_c       = tick_c && (rise_now_c || fall_now_c) && !abort_c;

  assign mark_ok_c  = rise_now_c && in_win(pw_q, 16'(MK_LO), 16'(MK_HI));
  assign lead_ok_c  = rise_now_c && in_win(pw_q, 16'(LM_LO), 16'(LM_HI));
  assign lsp_ok_c   = fall_now_c && in_win(pw_q, 16'(LS_LO), 16'(LS_HI));
  assign rsp_ok_c   = fall_now_c && in_win(pw_q, 16'(RS_LO), 16'(RS_HI));
  assign zero_c     = fall_now_c && in_win(pw_q, 16'(MK_LO), 16'(MK_HI));
  assign one_c      = fall_now_c && in_win(pw_q, 16'(S1_LO), 16'(S1_HI));

  assign frame_start_c = ev_c && (state_q == S_LEAD_SPACE) && lsp_ok_c;
  assign bit_c         = ev_c && (state_q == S_BIT_SPACE) && (zero_c || one_c);
  assign stop_ok_c     = ev_c && (state_q == S_STOP_MARK) && mark_ok_c;
  assign rep_ok_c      = ev_c && (state_q == S_REP_MARK) && mark_ok_c;

`ifdef IR_ADDR_CHECK_EN
  assign addr_ok_c = ((sr_q[7:0] ^ sr_q[15:8]) == 8'hFF);
`else
  logic unused_naddr_c;
  assign unused_naddr_c = ^sr_q[15:8];
  assign addr_ok_c = 1'b1;
`endif

  assign frame_ok_c = stop_ok_c && ((sr_q[23:16] ^ sr_q[31:24]) == 8'hFF) && addr_ok_c;
  assign rep_acc_c  = rep_ok_c && (code_q != 16'h0000);
  assign accept_c   = frame_ok_c || rep_acc_c;

  // State register
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: every edge is judged against its window on a tick
  always_comb begin
    state_d = state_q;
    if (abort_c) begin
      state_d = S_IDLE;
    end else if (ev_c) begin
      case (state_q)
        S_IDLE:       if (fall_now_c) state_d = S_LEAD_MARK;
        S_LEAD_MARK:  state_d = lead_ok_c ? S_LEAD_SPACE : S_IDLE;
        S_LEAD_SPACE: state_d = lsp_ok_c ? S_BIT_MARK : (rsp_ok_c ? S_REP_MARK : S_IDLE);
        S_BIT_MARK:   state_d = mark_ok_c ? S_BIT_SPACE : S_IDLE;
        S_BIT_SPACE:  state_d = (zero_c || one_c) ?
                                ((bit_idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK) : S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and outputs
  always_comb begin
    presc_d     = tick_c ? '0 : presc_q + PSW'(1);
    rise_pend_d = tick_c ? 1'b0 : rise_now_c;
    fall_pend_d = tick_c ? 1'b0 : fall_now_c;
    pw_d        = pw_q;
    bit_idx_d   = bit_idx_q;
    sr_d        = sr_q;
    rel_d       = rel_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    valid_d     = accept_c;
    if (tick_c) begin
      if (rise_now_c || fall_now_c) pw_d = 16'h0000;
      else if (pw_q != 16'hFFFF)    pw_d = pw_q + 16'd1;
    end
    if (frame_start_c) begin
      bit_idx_d = 5'd0;
      sr_d      = 32'h0;
    end else if (bit_c) begin
      bit_idx_d = bit_idx_q + 5'd1;
      sr_d      = {one_c, sr_q[31:1]};
    end
    if (accept_c)                                   rel_d = '0;
    else if (tick_c && (rel_q != RLW'(REL_TO_US))) rel_d = rel_q + RLW'(1);
    if (rel_q == RLW'(REL_TO_US)) begin
      code_d = 16'h0000;
      cnt_d  = 8'h00;
    end
    // Acceptance overrides a coincident release
    if (frame_ok_c) begin
      code_d = {sr_q[7:0], sr_q[23:16]};
      cnt_d  = 8'd1;
    end else if (rep_acc_c) begin
      code_d = code_q;
      cnt_d  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_d1_q     <= 1'b1;
      rise_pend_q <= 1'b0;
      fall_pend_q <= 1'b0;
      presc_q     <= '0;
      pw_q        <= 16'h0000;
      bit_idx_q   <= 5'd0;
      sr_q        <= 32'h0;
      rel_q       <= '0;
      code_q      <= 16'h0000;
      cnt_q       <= 8'h00;
      valid_q     <= 1'b0;
    end else begin
      rx_s1_q     <= ir_rx;
      rx_s2_q     <= rx_s1_q;
      rx_d1_q     <= rx_s2_q;
      rise_pend_q <= rise_pend_d;
      fall_pend_q <= fall_pend_d;
      presc_q     <= presc_d;
      pw_q        <= pw_d;
      bit_idx_q   <= bit_idx_d;
      sr_q        <= sr_d;
      rel_q       <= rel_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
    end
  end

  assign ir_code     = code_q;
  assign ir_code_cnt = cnt_q;
  assign ir_valid    = valid_q;
endmodule

// File: tb/tb_ir_nec_rcv.sv
// Directed bench for ir_nec_rcv with scaled timing (1 tick per clock, windows / 100).
module tb_ir_nec_rcv;
  localparam int unsigned TS  = 100;
  localparam int unsigned REL = 1300;

  logic        clk27   = 1'b0;
  logic        reset_n = 1'b0;
  logic        ir_rx   = 1'b1;
  logic [15:0] ir_code;
  logic [7:0]  ir_code_cnt;
  logic        ir_valid;

  int          total = 0;
  int          bad   = 0;
  logic [23:0] sb_q[$];
  logic [15:0] exp_code = 16'h0;
  logic [7:0]  exp_cnt  = 8'h0;
  logic        valid_prev = 1'b0;

  always #5 clk27 = ~clk27;

  ir_nec_rcv #(.PRESCALE(1), .REL_TO_US(REL), .TSCALE(TS)) dut (
    .clk27      (clk27),
    .reset_n    (reset_n),
    .ir_rx      (ir_rx),
    .ir_code    (ir_code),
    .ir_code_cnt(ir_code_cnt),
    .ir_valid   (ir_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each strobe pops the oldest expected {cnt, code}
  always @(negedge clk27) begin
    if (ir_valid) begin
      check("valid_b2b", 32'(valid_prev), 32'd0);
      check("valid_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        check("valid_word", {8'h0, ir_code_cnt, ir_code}, {8'h0, sb_q[0]});
        void'(sb_q.pop_front());
      end
    end
    valid_prev <= ir_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk27);
  endtask
  task automatic mark(input int n);
    ir_rx = 1'b0;
    cyc(n);
  endtask
  task automatic space(input int n);
    ir_rx = 1'b1;
    cyc(n);
  endtask

  task automatic send_bits(input logic [31:0] w, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      mark(6);
      space(w[i] ? 16 : 6);
    end
  endtask

  task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    mark(90);
    space(45);
    send_bits({b3, b2, b1, b0}, 0, 31);
    mark(6);
    ir_rx = 1'b1;
  endtask

  task automatic check_out(input string tag);
    check({tag, "_code"}, 32'(ir_code), 32'(exp_code));
    check({tag, "_cnt"}, 32'(ir_code_cnt), 32'(exp_cnt));
  endtask

  task automatic frame_ok(input string tag, input logic [7:0] a, input logic [7:0] c);
    exp_code = {a, c};
    exp_cnt  = 8'd1;
    sb_q.push_back({exp_cnt, exp_code});
    send_bytes(a, ~a, c, ~c);
    cyc(10);
    check({tag, "_strobe"}, 32'(sb_q.size()), 32'd0);
    check_out(tag);
  endtask

  task automatic rep(input int gap);
    if (exp_code != 16'h0) begin
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      sb_q.push_back({exp_cnt, exp_code});
    end
    mark(90);
    space(22);
    mark(6);
    ir_rx = 1'b1;
    cyc(gap);
  endtask

  initial begin
    cyc(5);
    check_out("reset");
    check("reset_valid", 32'(ir_valid), 32'd0);
    reset_n = 1'b1;
    cyc(20);

    frame_ok("t1", 8'h3E, 8'h12);

    frame_ok("t2f", 8'h3E, 8'h12);
    rep(960);
    rep(960);
    rep(10);
    check("t2_rep_strobes", 32'(sb_q.size()), 32'd0);
    check_out("t2_cnt4");
    cyc(1200);
    check_out("t2_held");
    cyc(200);
    exp_code = 16'h0;
    exp_cnt  = 8'h0;
    check_out("t2_release");
    rep(20);
    check_out("t2_orphan_rep");

    frame_ok("t3f", 8'h3E, 8'h12);
    for (int i = 0; i < 300; i++) rep(10);
    check("t3_strobes", 32'(sb_q.size()), 32'd0);
    check_out("t3_sat");

    send_bytes(8'h3E, 8'hC1, 8'h12, 8'h12);
    cyc(10);
    check_out("t4_badcmd");
    frame_ok("t4f", 8'h3E, 8'h12);
`ifndef IR_ADDR_CHECK_EN
    exp_code = 16'h3E55;
    exp_cnt  = 8'd1;
    sb_q.push_back({exp_cnt, exp_code});
`endif
    send_bytes(8'h3E, 8'h00, 8'h55, 8'hAA);
    cyc(10);
    check("t4_addr_strobe", 32'(sb_q.size()), 32'd0);
    check_out("t4_badaddr");

    mark(70);
    space(200);
    mark(90);
    space(45);
    send_bits(32'h0000_0002, 0, 1);
    mark(6);
    space(11);
    mark(6);
    space(200);
    frame_ok("t5f", 8'h00, 8'h45);
    mark(400);
    space(200);
    frame_ok("t5stuck", 8'h10, 8'h20);

    mark(90);
    space(45);
    send_bits(32'hED12_C13E, 0, 14);
    mark(6);
    ir_rx = 1'b1;
    cyc(3);
    reset_n = 1'b0;
    #1;
    exp_code = 16'h0;
    exp_cnt  = 8'h0;
    check_out("t6_rst");
    check("t6_rst_valid", 32'(ir_valid), 32'd0);
    cyc(3);
    reset_n = 1'b1;
    cyc(10);
    send_bits(32'hED12_C13E, 16, 31);
    mark(6);
    ir_rx = 1'b1;
    cyc(10);
    check_out("t6_tail");
    frame_ok("t6f", 8'h3E, 8'h12);

    cyc(20);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
